// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the keyboard envelope/mixer datapath.
//   env_state_t         : per-voice ADSR state encoding
//   DEFAULT_GAIN_MAX    : default full-scale envelope gain (GAIN_W = 8)
//   DEFAULT_SUSTAIN_LVL : default sustain gain
//   recip_lut(n)        : round(256/n), 0 for n = 0; used by mix normalisation
package piano_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        HOLD    = 3'd2,
        DECAY   = 3'd3,
        SUSTAIN = 3'd4,
        RELEASE = 3'd5
    } env_state_t;

    localparam int DEFAULT_GAIN_MAX    = 255;
    localparam int DEFAULT_SUSTAIN_LVL = 192;

    function automatic logic [8:0] recip_lut(input int unsigned n);
        if (n == 0) begin
            return 9'd0;
        end
        return 9'((256 + n / 2) / n);
    endfunction

endpackage

// File: rtl/voice_envelope.sv
// voice_envelope: one ADSR state machine and gain register for a single voice.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : one-cycle envelope step strobe (shared by all voices)
//   rise, fall   : registered key-down / key-up pulses for this voice
//   gain         : current envelope gain (registered)
//   active       : 1 when the voice is not IDLE (registered with the state)
module voice_envelope
    import piano_pkg::*;
#(
    parameter int GAIN_W      = 8,
    parameter int ATTACK_INC  = 8,
    parameter int HOLD_TICKS  = 64,
    parameter int DECAY_DEC   = 1,
    parameter int SUSTAIN_LVL = DEFAULT_SUSTAIN_LVL,
    parameter int RELEASE_DEC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              rise,
    input  logic              fall,
    output logic [GAIN_W-1:0] gain,
    output logic              active
);

    localparam int W1     = GAIN_W + 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [GAIN_W:0]   GAIN_MAX  = W1'((1 << GAIN_W) - 1);
    localparam logic [GAIN_W:0]   INC       = W1'(ATTACK_INC);
    localparam logic [GAIN_W:0]   DDEC      = W1'(DECAY_DEC);
    localparam logic [GAIN_W:0]   RDEC      = W1'(RELEASE_DEC);
    localparam logic [GAIN_W:0]   SUS       = W1'(SUSTAIN_LVL);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    env_state_t        state, state_nx;
    logic [GAIN_W-1:0] gain_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [GAIN_W:0]   up, dn_decay, dn_rel;
    logic              key_phase;

    // Steps are computed one bit wider so the MSB flags overflow/borrow for clamping.
    always_comb begin
        up        = {1'b0, gain} + INC;
        dn_decay  = {1'b0, gain} - DDEC;
        dn_rel    = {1'b0, gain} - RDEC;
        key_phase = (state == ATTACK) || (state == HOLD) ||
                    (state == DECAY)  || (state == SUSTAIN);
        state_nx  = state;
        gain_nx   = gain;
        hold_nx   = hold_cnt;

        // Key events take priority over a coincident tick: no gain step that cycle.
        if (rise && (state == IDLE || state == RELEASE)) begin
            state_nx = ATTACK;
        end else if (fall && key_phase) begin
            state_nx = RELEASE;
        end else if (tick) begin
            case (state)
                ATTACK: begin
                    if (up >= GAIN_MAX) begin
                        gain_nx  = '1;
                        state_nx = HOLD;
                        hold_nx  = '0;
                    end else begin
                        gain_nx = up[GAIN_W-1:0];
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nx = DECAY;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                DECAY: begin
                    if (dn_decay[GAIN_W] || (dn_decay <= SUS)) begin
                        gain_nx  = SUS[GAIN_W-1:0];
                        state_nx = SUSTAIN;
                    end else begin
                        gain_nx = dn_decay[GAIN_W-1:0];
                    end
                end
                RELEASE: begin
                    if (dn_rel[GAIN_W] || (dn_rel == '0)) begin
                        gain_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        gain_nx = dn_rel[GAIN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gain     <= '0;
            hold_cnt <= '0;
            active   <= 1'b0;
        end else begin
            state    <= state_nx;
            gain     <= gain_nx;
            hold_cnt <= hold_nx;
            active   <= (state_nx != IDLE);
        end
    end

endmodule

// File: rtl/voice_envelope_mixer.sv
// voice_envelope_mixer: per-voice ADSR gain applied to voice samples, then mixed.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   note_on      : per-voice key-held level
//   sample_in    : packed unsigned voice samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   wave         : mixed, saturated, registered output sample
//   voice_active : bit i set while voice i is not IDLE
// Build option MIX_AUTOSCALE_EN: normalise the mix by the number of active voices
// (sum * round(256/n) >> 8); otherwise a fixed shift by $clog2(NUM_VOICES).
module voice_envelope_mixer
    import piano_pkg::*;
#(
    parameter int NUM_VOICES  = 3,
    parameter int SAMPLE_W    = 8,
    parameter int GAIN_W      = 8,
    parameter int TICK_DIV    = 312500,
    parameter int ATTACK_INC  = 8,
    parameter int HOLD_TICKS  = 64,
    parameter int DECAY_DEC   = 1,
    parameter int SUSTAIN_LVL = DEFAULT_SUSTAIN_LVL,
    parameter int RELEASE_DEC = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_VOICES-1:0]          note_on,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0]            wave,
    output logic [NUM_VOICES-1:0]          voice_active
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES + 1);
    localparam int PROD_W = SAMPLE_W + GAIN_W;
`ifdef MIX_AUTOSCALE_EN
    localparam int MIX_W  = SUM_W + 9;
`else
    localparam int MIX_W       = SUM_W;
    localparam int FIXED_SHIFT = $clog2(NUM_VOICES);
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [MIX_W-1:0] SAT      = MIX_W'((1 << SAMPLE_W) - 1);

    // ---------------- tick prescaler ----------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    always_comb begin
        tick = (tick_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ---------------- key edge detect ----------------
    // rise/fall are registered so the FSM moves one edge after the edge-detect cycle.
    // armed stays low until a key has been seen released since reset, so a key
    // held through reset does not start a voice until it is lifted and pressed again.
    logic [NUM_VOICES-1:0] note_on_q, armed, rise, fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_on_q <= '0;
            armed     <= '0;
            rise      <= '0;
            fall      <= '0;
        end else begin
            note_on_q <= note_on;
            armed     <= armed | ~note_on;
            rise      <= note_on & ~note_on_q & armed;
            fall      <= ~note_on & note_on_q;
        end
    end

    // ---------------- per-voice envelopes ----------------
    logic [GAIN_W-1:0] gain [NUM_VOICES];

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_envelope #(
            .GAIN_W      (GAIN_W),
            .ATTACK_INC  (ATTACK_INC),
            .HOLD_TICKS  (HOLD_TICKS),
            .DECAY_DEC   (DECAY_DEC),
            .SUSTAIN_LVL (SUSTAIN_LVL),
            .RELEASE_DEC (RELEASE_DEC)
        ) u_env (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .rise    (rise[v]),
            .fall    (fall[v]),
            .gain    (gain[v]),
            .active  (voice_active[v])
        );
    end

    // ---------------- scale stage ----------------
    logic [SAMPLE_W-1:0] scaled [NUM_VOICES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                scaled[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                scaled[i] <= SAMPLE_W'((PROD_W'(sample_in[i*SAMPLE_W +: SAMPLE_W]) *
                                        PROD_W'(gain[i])) >> GAIN_W);
            end
        end
    end

    // ---------------- mix stage ----------------
    logic [SUM_W-1:0]    sum;
    logic [MIX_W-1:0]    mixed;
    logic [SAMPLE_W-1:0] wave_nx;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            sum = sum + SUM_W'(scaled[i]);
        end
`ifdef MIX_AUTOSCALE_EN
        // recip_lut(0) is 0, so an all-idle mix yields 0.
        mixed = (MIX_W'(sum) * MIX_W'(recip_lut($countones(voice_active)))) >> 8;
`else
        mixed = sum >> FIXED_SHIFT;
`endif
        wave_nx = (mixed > SAT) ? SAT[SAMPLE_W-1:0] : mixed[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave <= '0;
        end else begin
            wave <= wave_nx;
        end
    end

endmodule

// File: tb/tb_voice_envelope_mixer.sv
module tb_voice_envelope_mixer;

    localparam int NV          = 3;
    localparam int SW          = 8;
    localparam int TICK_DIV    = 4;
    localparam int ATTACK_INC  = 64;
    localparam int HOLD_TICKS  = 2;
    localparam int DECAY_DEC   = 32;
    localparam int SUSTAIN_LVL = 128;
    localparam int RELEASE_DEC = 64;
    localparam int GMAX        = 255;

    // model phase names
    localparam int S_IDLE = 0, S_ATK = 1, S_HOLD = 2, S_DEC = 3, S_SUS = 4, S_REL = 5;

`ifdef MIX_AUTOSCALE_EN
    localparam int EXP_MIX3 = 198;
    localparam int EXP_MIX1 = 199;
`else
    localparam int EXP_MIX3 = 149;
    localparam int EXP_MIX1 = 49;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NV-1:0]    note_on = '0;
    logic [NV*SW-1:0] sample_in = '0;
    logic [SW-1:0]    wave;
    logic [NV-1:0]    voice_active;

    voice_envelope_mixer #(
        .NUM_VOICES  (NV),
        .SAMPLE_W    (SW),
        .GAIN_W      (8),
        .TICK_DIV    (TICK_DIV),
        .ATTACK_INC  (ATTACK_INC),
        .HOLD_TICKS  (HOLD_TICKS),
        .DECAY_DEC   (DECAY_DEC),
        .SUSTAIN_LVL (SUSTAIN_LVL),
        .RELEASE_DEC (RELEASE_DEC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .note_on      (note_on),
        .sample_in    (sample_in),
        .wave         (wave),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]      wave;
        logic [NV-1:0]   act;
        logic [NV*8-1:0] gains;
    } exp_t;

    exp_t exp_q[$];

    int            m_st [NV];
    int            m_g  [NV];
    int            m_hc [NV];
    int            m_sc [NV];
    int            m_wave;
    int            m_cnt;
    logic [NV-1:0] m_act, m_prev, m_arm, m_rp, m_fp;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_st[i] = S_IDLE; m_g[i] = 0; m_hc[i] = 0; m_sc[i] = 0;
        end
        m_wave = 0; m_cnt = 0;
        m_act = '0; m_prev = '0; m_arm = '0; m_rp = '0; m_fp = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int   sum, mixed, s;
        bit   tick;
        exp_t e;
        sum = 0;
        for (int i = 0; i < NV; i++) sum += m_sc[i];
`ifdef MIX_AUTOSCALE_EN
        begin
            int n;
            n = $countones(m_act);
            mixed = (n == 0) ? 0 : (sum * ((256 + n / 2) / n)) / 256;
        end
`else
        mixed = sum / (1 << $clog2(NV));
`endif
        m_wave = (mixed > 255) ? 255 : mixed;

        for (int i = 0; i < NV; i++) begin
            s = int'(sample_in[i*SW +: SW]);
            m_sc[i] = (s * m_g[i]) / 256;
        end

        tick = (m_cnt == TICK_DIV - 1);
        for (int i = 0; i < NV; i++) begin
            if (m_rp[i] && (m_st[i] == S_IDLE || m_st[i] == S_REL)) begin
                m_st[i] = S_ATK;
            end else if (m_fp[i] && m_st[i] != S_IDLE && m_st[i] != S_REL) begin
                m_st[i] = S_REL;
            end else if (tick) begin
                case (m_st[i])
                    S_ATK: begin
                        m_g[i] = m_g[i] + ATTACK_INC;
                        if (m_g[i] >= GMAX) begin m_g[i] = GMAX; m_st[i] = S_HOLD; m_hc[i] = 0; end
                    end
                    S_HOLD: begin
                        m_hc[i]++;
                        if (m_hc[i] == HOLD_TICKS) m_st[i] = S_DEC;
                    end
                    S_DEC: begin
                        m_g[i] = m_g[i] - DECAY_DEC;
                        if (m_g[i] <= SUSTAIN_LVL) begin m_g[i] = SUSTAIN_LVL; m_st[i] = S_SUS; end
                    end
                    S_REL: begin
                        m_g[i] = m_g[i] - RELEASE_DEC;
                        if (m_g[i] <= 0) begin m_g[i] = 0; m_st[i] = S_IDLE; end
                    end
                    default: ;
                endcase
            end
            m_act[i] = (m_st[i] != S_IDLE);
        end

        m_rp   = note_on & ~m_prev & m_arm;
        m_fp   = ~note_on & m_prev;
        m_arm  = m_arm | ~note_on;
        m_prev = note_on;
        m_cnt  = tick ? 0 : m_cnt + 1;

        e.wave = 8'(m_wave);
        e.act  = m_act;
        for (int i = 0; i < NV; i++) e.gains[i*8 +: 8] = 8'(m_g[i]);
        exp_q.push_back(e);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wave", int'(wave), int'(e.wave));
            check("voice_active", int'(voice_active), int'(e.act));
            for (int i = 0; i < NV; i++)
                check($sformatf("gain%0d", i), int'(dut.gain[i]), int'(e.gains[i*8 +: 8]));
        end
    end

    // ---------------- directed helpers ----------------
    int trace_exp[$];

    task automatic expect_trace(input int v, input int budget, input string tag);
        int last, idx, k;
        last = int'(dut.gain[v]); idx = 0; k = 0;
        while (idx < trace_exp.size() && k < budget) begin
            @(negedge clk);
            k++;
            if (int'(dut.gain[v]) != last) begin
                last = int'(dut.gain[v]);
                check($sformatf("%s[%0d]", tag, idx), last, trace_exp[idx]);
                idx++;
            end
        end
        check({tag, "_steps"}, idx, trace_exp.size());
    endtask

    task automatic wait_gain(input int v, input int val, input int budget, input string tag);
        int k;
        k = 0;
        while (int'(dut.gain[v]) != val && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(dut.gain[v]), val);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (voice_active != '0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(voice_active), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, g0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_wave", int'(wave), 0);
        check("reset_active", int'(voice_active), 0);
        for (int i = 0; i < NV; i++) check($sformatf("reset_gain%0d", i), int'(dut.gain[i]), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // envelope trace on voice 0
        note_on = 3'b001;
        trace_exp = {64, 128, 192, 255, 223, 191, 159, 128};
        expect_trace(0, 120, "attack_decay");
        repeat (20) @(negedge clk);
        check("sustain_gain", int'(dut.gain[0]), SUSTAIN_LVL);
        check("sustain_active", int'(voice_active[0]), 1);

        // release to 64, retrigger from there
        note_on = 3'b000;
        trace_exp = {64};
        expect_trace(0, 40, "release");
        note_on = 3'b001;
        trace_exp = {128};
        expect_trace(0, 40, "retrigger");
        note_on = 3'b000;
        trace_exp = {64, 0};
        expect_trace(0, 40, "release_idle");
        repeat (2) @(negedge clk);
        check("idle_active0", int'(voice_active[0]), 0);

        // three-voice mix with 2-cycle latency
        sample_in = '0;
        note_on = 3'b111;
        wait_gain(0, GMAX, 100, "mix3_reach_max");
        sample_in = {8'd200, 8'd200, 8'd200};
        @(negedge clk);
        check("mix3_latency1", int'(wave), 0);
        @(negedge clk);
        check("mix3_wave", int'(wave), EXP_MIX3);

        // single voice
        note_on = '0;
        wait_idle(100, "idle_before_single");
        sample_in = {8'(($urandom_range(1, 255))), 8'(($urandom_range(1, 255))), 8'd0};
        note_on = 3'b001;
        wait_gain(0, GMAX, 100, "single_reach_max");
        sample_in[7:0] = 8'd200;
        @(negedge clk);
        check("single_latency1", int'(wave), 0);
        @(negedge clk);
        check("single_wave", int'(wave), EXP_MIX1);

        // asynchronous reset mid-attack
        note_on = '0;
        wait_idle(100, "idle_before_reset");
        sample_in = '1;
        note_on = 3'b010;
        wait_gain(1, 128, 100, "reset_attack_gain");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_wave", int'(wave), 0);
        check("async_reset_active", int'(voice_active), 0);
        check("async_reset_gain1", int'(dut.gain[1]), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_through_reset", int'(voice_active), 0);
        note_on = 3'b000;
        repeat (2) @(negedge clk);
        note_on = 3'b010;
        @(negedge clk);
        check("rise_edge1_active", int'(voice_active[1]), 0);
        @(negedge clk);
        check("rise_edge2_active", int'(voice_active[1]), 1);

        // fall coinciding with a tick in DECAY
        note_on = '0;
        wait_idle(100, "idle_before_decay");
        note_on = 3'b100;
        k = 0;
        while (!(m_st[2] == S_DEC && m_cnt == TICK_DIV - 2) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("decay_reached", int'(m_st[2] == S_DEC && m_cnt == TICK_DIV - 2), 1);
        g0 = m_g[2];
        note_on = 3'b000;
        repeat (2) @(negedge clk);
        check("fall_tick_gain", int'(dut.gain[2]), g0);
        check("fall_tick_active", int'(voice_active[2]), 1);
        repeat (TICK_DIV) @(negedge clk);
        check("fall_tick_next", int'(dut.gain[2]), (g0 > RELEASE_DEC) ? g0 - RELEASE_DEC : 0);
        wait_idle(100, "idle_before_random");

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int v = 0; v < NV; v++)
                if ($urandom_range(0, 29) == 0) note_on[v] = ~note_on[v];
            sample_in = (NV*SW)'($urandom());
            if ($urandom_range(0, 9) == 0) sample_in = '1;
        end
        note_on = '0;
        repeat (100) @(negedge clk);
        check("final_idle", int'(voice_active), 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
